// File: rtl/mem_stall_ctrl.sv
// MEM-stage access sequencer: runs the req/ready handshake with data memory,
// holds the upstream pipeline while an access is in flight, and detects load-use hazards.
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] MemDin_mem,
  input  logic        MemRead_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic [4:0]  rs1Addr_id,
  input  logic [4:0]  rs2Addr_id,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] MemDout_mem,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        flush_idex,
  output logic        bubble_wb,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] to_cnt;
  logic       access;
  logic       mem_stall;
  logic       load_use;

  assign access = MemRead_mem | MemWrite_mem;

  // DONE deliberately releases the stall even though the access is still
  // visible in EX/MEM: this is the cycle in which the pipeline advances.
  assign mem_stall = ((state == IDLE) && access) || (state == BUSY);

  assign load_use = MemRead_ex && (rdAddr_ex != 5'd0) &&
                    ((rdAddr_ex == rs1Addr_id) || (rdAddr_ex == rs2Addr_id));

  always_comb begin
    stall_pc    = mem_stall | load_use;
    stall_ifid  = mem_stall | load_use;
    stall_idex  = mem_stall;
    stall_exmem = mem_stall;
    bubble_wb   = mem_stall;
    // A memory stall holds ID/EX, so a pending hazard must not flush it.
    flush_idex  = load_use & ~mem_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      to_cnt      <= 8'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      MemDout_mem <= 32'd0;
      bus_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            mem_addr  <= ALUResult_mem;
            mem_wdata <= MemDin_mem;
            mem_we    <= MemWrite_mem;
            mem_req   <= 1'b1;
            to_cnt    <= 8'd0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!mem_we) begin
              MemDout_mem <= mem_rdata;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= DONE;
          end else if (to_cnt == TO_LAST) begin
            MemDout_mem <= ERR_DATA;
            bus_err     <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            state       <= DONE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  a_req_only_busy: assert property (@(posedge clk) disable iff (!rst_n)
    mem_req == (state == BUSY));

  a_no_flush_while_held: assert property (@(posedge clk) disable iff (!rst_n)
    !(flush_idex && stall_idex));

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Bench for mem_stall_ctrl: table-driven hazard vectors plus scoreboarded
// memory access sequences (ready latency, store, timeout, async reset).
module tb_mem_stall_ctrl;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead_mem, MemWrite_mem;
  logic [31:0] ALUResult_mem, MemDin_mem;
  logic        MemRead_ex;
  logic [4:0]  rdAddr_ex, rs1Addr_id, rs2Addr_id;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, MemDout_mem;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic        flush_idex, bubble_wb, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] dout;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_dout;
  logic        m_err;

  typedef struct {
    logic       rd_ex;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       e_stall_pc;
    logic       e_stall_ifid;
    logic       e_stall_idex;
    logic       e_flush;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mem_stall_ctrl #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
    .ALUResult_mem(ALUResult_mem), .MemDin_mem(MemDin_mem),
    .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .MemDout_mem(MemDout_mem),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .flush_idex(flush_idex),
    .bubble_wb(bubble_wb), .bus_err(bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic hz_model();
    return MemRead_ex && (rdAddr_ex != 5'd0) &&
           ((rdAddr_ex == rs1Addr_id) || (rdAddr_ex == rs2Addr_id));
  endfunction

  // k < 0 means mem_ready is never given (timeout path).
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int k, input logic [31:0] rdata);
    int   busy = 0, stalls = 0, bubs = 0, bad = 0, flushes = 0, exp_busy;
    logic done = 1'b0;
    exp_t e;
    exp_busy = (k < 0) ? TIMEOUT : k + 1;
    if (k < 0) begin
      m_dout = ERR_DATA;
      m_err  = 1'b1;
    end else if (!wr) begin
      m_dout = rdata;
    end
    sb.push_back('{dout: m_dout, err: m_err});

    @(posedge clk); #1;
    MemRead_mem   = rd;
    MemWrite_mem  = wr;
    ALUResult_mem = addr;
    MemDin_mem    = wdata;
    mem_ready     = 1'b0;
    @(negedge clk);
    if (stall_exmem) stalls++;
    if (bubble_wb) bubs++;
    if (flush_idex) flushes++;
    check({tag, "/req_at_detect"}, {31'd0, mem_req}, 32'd0);

    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      if (mem_req) begin
        mem_ready     = (k >= 0) && (busy == k);
        mem_rdata     = mem_ready ? rdata : $urandom;
        ALUResult_mem = $urandom;
        MemDin_mem    = $urandom;
        busy++;
        @(negedge clk);
        if (stall_exmem) stalls++;
        if (bubble_wb) bubs++;
        if (flush_idex) flushes++;
        if (mem_addr !== addr || mem_wdata !== wdata || mem_we !== wr ||
            !stall_pc || !stall_ifid || !stall_idex) bad++;
      end else begin
        mem_ready = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        check({tag, "/dout"}, MemDout_mem, e.dout);
        check({tag, "/bus_err"}, {31'd0, bus_err}, {31'd0, e.err});
        check({tag, "/done_stall"}, {31'd0, stall_exmem}, 32'd0);
        check({tag, "/done_bubble"}, {31'd0, bubble_wb}, 32'd0);
        check({tag, "/done_flush"}, {31'd0, flush_idex}, {31'd0, hz_model()});
        check({tag, "/done_stall_pc"}, {31'd0, stall_pc}, {31'd0, hz_model()});
        done = 1'b1;
      end
    end
    check({tag, "/completed_in_bound"}, {31'd0, done}, 32'd1);
    check({tag, "/busy_cycles"}, busy, exp_busy);
    check({tag, "/stall_cycles"}, stalls, exp_busy + 1);
    check({tag, "/bubble_cycles"}, bubs, exp_busy + 1);
    check({tag, "/hold_bad_cycles"}, bad, 0);
    check({tag, "/flush_in_stall"}, flushes, 0);

    @(posedge clk); #1;
    MemRead_mem  = 1'b0;
    MemWrite_mem = 1'b0;
    @(negedge clk);
    check({tag, "/idle_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "/idle_stall"}, {31'd0, stall_exmem}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd7,  5'd7,  5'd3,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 5'd7,  5'd7,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'd9,  5'd8,  5'd10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd31, 5'd1,  5'd31, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 5'd0,  5'd5,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 5'd12, 5'd12, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    MemRead_mem = 1'b0; MemWrite_mem = 1'b0;
    ALUResult_mem = 32'd0; MemDin_mem = 32'd0;
    MemRead_ex = 1'b0; rdAddr_ex = 5'd0; rs1Addr_id = 5'd0; rs2Addr_id = 5'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    m_dout = 32'd0; m_err = 1'b0;

    #12;
    check("rst/mem_req", {31'd0, mem_req}, 32'd0);
    check("rst/mem_we", {31'd0, mem_we}, 32'd0);
    check("rst/mem_addr", mem_addr, 32'd0);
    check("rst/mem_wdata", mem_wdata, 32'd0);
    check("rst/dout", MemDout_mem, 32'd0);
    check("rst/bus_err", {31'd0, bus_err}, 32'd0);
    check("rst/stall_pc", {31'd0, stall_pc}, 32'd0);
    check("rst/flush", {31'd0, flush_idex}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      MemRead_ex = vecs[i].rd_ex;
      rdAddr_ex  = vecs[i].rd;
      rs1Addr_id = vecs[i].rs1;
      rs2Addr_id = vecs[i].rs2;
      @(negedge clk);
      check($sformatf("vec%0d/stall_pc", i), {31'd0, stall_pc}, {31'd0, vecs[i].e_stall_pc});
      check($sformatf("vec%0d/stall_ifid", i), {31'd0, stall_ifid}, {31'd0, vecs[i].e_stall_ifid});
      check($sformatf("vec%0d/stall_idex", i), {31'd0, stall_idex}, {31'd0, vecs[i].e_stall_idex});
      check($sformatf("vec%0d/flush_idex", i), {31'd0, flush_idex}, {31'd0, vecs[i].e_flush});
      check($sformatf("vec%0d/bubble_wb", i), {31'd0, bubble_wb}, 32'd0);
    end
    MemRead_ex = 1'b0; rdAddr_ex = 5'd0; rs1Addr_id = 5'd0; rs2Addr_id = 5'd0;

    do_access("load_k0", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h1234_5678);
    do_access("store_k3", 1'b0, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 3, 32'h5555_AAAA);
    do_access("rdwr_as_write", 1'b1, 1'b1, 32'h0000_0204, 32'h0BAD_F00D, 1, 32'h7777_7777);

    MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs1Addr_id = 5'd1; rs2Addr_id = 5'd5;
    do_access("load_hazard", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 2, 32'hCAFE_F00D);
    MemRead_ex = 1'b0; rdAddr_ex = 5'd0; rs1Addr_id = 5'd0; rs2Addr_id = 5'd0;

    do_access("load_timeout", 1'b1, 1'b0, 32'h0000_0400, 32'h0, -1, 32'h0);

    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      mem_ready = 1'b1;
      mem_rdata = 32'h1111_1111;
      @(negedge clk);
      check("stray_ready/req", {31'd0, mem_req}, 32'd0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("stray_ready/dout", MemDout_mem, m_dout);

    do_access("load_after_err", 1'b1, 1'b0, 32'h0000_0500, 32'h0, 1, 32'h0F0F_1234);

    @(posedge clk); #1;
    MemRead_mem = 1'b1;
    ALUResult_mem = 32'h0000_0600;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("midbusy/req_before_rst", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midbusy/mem_req", {31'd0, mem_req}, 32'd0);
    check("midbusy/mem_we", {31'd0, mem_we}, 32'd0);
    check("midbusy/mem_addr", mem_addr, 32'd0);
    check("midbusy/mem_wdata", mem_wdata, 32'd0);
    check("midbusy/dout", MemDout_mem, 32'd0);
    check("midbusy/bus_err", {31'd0, bus_err}, 32'd0);
    MemRead_mem = 1'b0;
    #1;
    check("midbusy/stall_pc", {31'd0, stall_pc}, 32'd0);
    check("midbusy/bubble", {31'd0, bubble_wb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_dout = 32'd0;
    m_err  = 1'b0;
    @(negedge clk);
    check("post_rst/req", {31'd0, mem_req}, 32'd0);
    check("post_rst/stall", {31'd0, stall_exmem}, 32'd0);

    do_access("load_post_rst", 1'b1, 1'b0, 32'h0000_0700, 32'h0, 0, 32'h8765_4321);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout, want completion");
    $fatal(1, "time limit");
  end

endmodule
